// File: rtl/vga_pixel_fetch_if.sv
// Memory read bus between the pixel fetcher (master) and the framebuffer memory (slave).
interface vga_pixel_fetch_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_in;

  modport master (output bus_req, output bus_addr, input bus_ack, input bus_in);
  modport slave  (input bus_req, input bus_addr, output bus_ack, output bus_in);
endinterface

// File: rtl/vga_pixel_fetch.sv
// Framebuffer word fetcher feeding a word FIFO that is unpacked MSB-first into 8-bit pixels.
module vga_pixel_fetch #(
  parameter logic [31:0] FB_BASE    = 32'h0000_0000,
  parameter int unsigned FB_WORDS   = 19200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk25MHz,
  input  logic              reset,
  input  logic              frame_start,
  vga_pixel_fetch_if.master bus,
  input  logic              pix_rd,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  output logic              underflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WcW  = $clog2(FB_WORDS + 1);

  localparam logic [31:0]     BaseAddr  = {FB_BASE[31:2], 2'b00};
  localparam logic [CntW-1:0] DepthCnt  = CntW'(FIFO_DEPTH);
  localparam logic [WcW-1:0]  FullWords = WcW'(FB_WORDS);
  localparam logic [WcW-1:0]  LastWord  = WcW'(FB_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDrain, StDone} state_e;

  state_e          state_q;
  logic            bus_req_q;
  logic [31:0]     bus_addr_q;
  logic [WcW-1:0]  word_cnt_q;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] fifo_cnt_q;
  logic [1:0]      byte_ptr_q;
  logic            underflow_q;

  logic            wr_en;
  logic            pop_byte;
  logic            pop_word;
  logic [31:0]     head;

  assign bus.bus_req  = bus_req_q;
  assign bus.bus_addr = bus_addr_q;

  // Only acks for live requests land in the FIFO; a coincident frame_start discards the word.
  assign wr_en     = (state_q == StReq) && bus.bus_ack && !frame_start;
  assign pix_valid = (fifo_cnt_q != '0);
  assign pop_byte  = pix_rd && pix_valid && !frame_start;
  assign pop_word  = pop_byte && (byte_ptr_q == 2'd3);
  assign underflow = underflow_q;

  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bus_req_q  <= 1'b0;
      bus_addr_q <= BaseAddr;
      word_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            bus_addr_q <= BaseAddr;
            word_cnt_q <= '0;
          end else if (word_cnt_q == FullWords) begin
            state_q <= StDone;
          end else if (fifo_cnt_q < DepthCnt) begin
            state_q   <= StReq;
            bus_req_q <= 1'b1;
          end
        end
        StReq: begin
          if (bus.bus_ack) begin
            bus_req_q <= 1'b0;
            if (frame_start) begin
              state_q    <= StIdle;
              bus_addr_q <= BaseAddr;
              word_cnt_q <= '0;
            end else begin
              bus_addr_q <= bus_addr_q + 32'd4;
              word_cnt_q <= word_cnt_q + 1'b1;
              state_q    <= (word_cnt_q == LastWord) ? StDone : StIdle;
            end
          end else if (frame_start) begin
            // The bus cycle must still complete, so hold req/addr and swallow the ack later.
            state_q    <= StDrain;
            word_cnt_q <= '0;
          end
        end
        StDrain: begin
          if (bus.bus_ack) begin
            state_q    <= StIdle;
            bus_req_q  <= 1'b0;
            bus_addr_q <= BaseAddr;
            word_cnt_q <= '0;
          end
        end
        StDone: begin
          if (frame_start) begin
            state_q    <= StIdle;
            bus_addr_q <= BaseAddr;
            word_cnt_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= bus.bus_in;
    end
  end

  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      byte_ptr_q  <= 2'd0;
      underflow_q <= 1'b0;
    end else if (frame_start) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      byte_ptr_q  <= 2'd0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_word) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (pop_byte) begin
        byte_ptr_q <= byte_ptr_q + 2'd1;
      end
      unique case ({wr_en, pop_word})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (pix_rd && !pix_valid) begin
        underflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    head     = mem[rd_ptr_q];
    pix_data = 8'h00;
    if (pix_valid) begin
      unique case (byte_ptr_q)
        2'd0:    pix_data = head[31:24];
        2'd1:    pix_data = head[23:16];
        2'd2:    pix_data = head[15:8];
        default: pix_data = head[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed self-checking bench for vga_pixel_fetch: fill, unpack, ack stall, drain and frame end.
module tb_vga_pixel_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       pix_rd = 1'b0;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       underflow;

  logic       frame_start2 = 1'b0;
  logic       pix_rd2 = 1'b0;
  logic [7:0] pix_data2;
  logic       pix_valid2;
  logic       underflow2;

  int checks = 0;
  int failures = 0;

  vga_pixel_fetch_if bus_if ();
  vga_pixel_fetch_if bus2_if ();

  vga_pixel_fetch dut (
    .clk25MHz    (clk),
    .reset       (rst),
    .frame_start (frame_start),
    .bus         (bus_if),
    .pix_rd      (pix_rd),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underflow   (underflow)
  );

  vga_pixel_fetch #(.FB_WORDS(4)) dut_small (
    .clk25MHz    (clk),
    .reset       (rst),
    .frame_start (frame_start2),
    .bus         (bus2_if),
    .pix_rd      (pix_rd2),
    .pix_data    (pix_data2),
    .pix_valid   (pix_valid2),
    .underflow   (underflow2)
  );

  always #20 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    frame_start = 1'b0;
    frame_start2 = 1'b0;
    pix_rd = 1'b0;
    #5 rst = 1'b0;
  endtask

  task automatic wait_req(input int max_cycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(negedge clk);
      if (bus_if.bus_req) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus_if.bus_ack = 1'b1;
    bus_if.bus_in = 32'hAABBCCDD;
    bus2_if.bus_ack = 1'b1;
    bus2_if.bus_in = 32'h55667788;
    #10;
    checks++;
    if (bus_if.bus_req !== 1'b0 || bus_if.bus_addr !== 32'h0 || pix_valid !== 1'b0 ||
        pix_data !== 8'h00 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: req=%b addr=%h valid=%b data=%h uf=%b, need 0 0 0 00 0",
               bus_if.bus_req, bus_if.bus_addr, pix_valid, pix_data, underflow);
    end
    checks++;
    if (bus2_if.bus_req !== 1'b0 || bus2_if.bus_addr !== 32'h0 || pix_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state_small: req=%b addr=%h valid=%b, need 0 0 0",
               bus2_if.bus_req, bus2_if.bus_addr, pix_valid2);
    end
    #20 rst = 1'b0;
  endtask

  task automatic test_fill();
    int n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_if.bus_req) begin
        checks++;
        if (bus_if.bus_addr !== 32'(n * 4)) begin
          failures++;
          $display("FAIL fill_addr: req %0d addr=%h, need %h", n, bus_if.bus_addr, n * 4);
        end
        n++;
      end
    end
    checks++;
    if (n != 16 || bus_if.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL fill_count: requests=%0d req=%b, need 16 and 0", n, bus_if.bus_req);
    end
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'hAA) begin
      failures++;
      $display("FAIL fill_head: valid=%b data=%h, need 1 AA", pix_valid, pix_data);
    end
  endtask

  task automatic test_pixels();
    logic [7:0] exp_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int n = 0;
    logic [31:0] first_addr = 32'hFFFF_FFFF;
    pix_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pix_data !== exp_b[i]) begin
        failures++;
        $display("FAIL pixel_order: byte %0d data=%h, need %h", i, pix_data, exp_b[i]);
      end
      @(negedge clk);
    end
    pix_rd = 1'b0;
    checks++;
    if (pix_data !== 8'hAA || pix_valid !== 1'b1) begin
      failures++;
      $display("FAIL pixel_next_word: data=%h valid=%b, need AA 1", pix_data, pix_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_if.bus_req) begin
        if (n == 0) first_addr = bus_if.bus_addr;
        n++;
      end
    end
    checks++;
    if (n != 1 || first_addr !== 32'h40) begin
      failures++;
      $display("FAIL refill_one: requests=%0d addr=%h, need 1 at 00000040", n, first_addr);
    end
  endtask

  task automatic test_ack_delay();
    bit found;
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus_if.bus_ack = 1'b0;
    bus_if.bus_in = 32'h11223344;
    do_reset();
    wait_req(10, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL ack_delay_first_req: req never rose, need 1 within 10 cycles");
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h0) begin
        failures++;
        $display("FAIL ack_delay_hold: cycle %0d req=%b addr=%h, need 1 00000000",
                 i, bus_if.bus_req, bus_if.bus_addr);
      end
      @(negedge clk);
    end
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    checks++;
    if (bus_if.bus_req !== 1'b0 || pix_valid !== 1'b1 || pix_data !== 8'h11) begin
      failures++;
      $display("FAIL ack_delay_write: req=%b valid=%b data=%h, need 0 1 11",
               bus_if.bus_req, pix_valid, pix_data);
    end
    wait_req(5, found);
    checks++;
    if (!found || bus_if.bus_addr !== 32'h4) begin
      failures++;
      $display("FAIL ack_delay_next_addr: found=%b addr=%h, need 1 00000004",
               found, bus_if.bus_addr);
    end
    pix_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pix_data !== exp_b[i]) begin
        failures++;
        $display("FAIL ack_delay_bytes: byte %0d data=%h, need %h", i, pix_data, exp_b[i]);
      end
      @(negedge clk);
    end
    pix_rd = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || pix_data !== 8'h00) begin
      failures++;
      $display("FAIL ack_delay_once: valid=%b data=%h, need 0 00", pix_valid, pix_data);
    end
  endtask

  task automatic test_fs_drain();
    bit found = 1'b0;
    bus_if.bus_ack = 1'b1;
    bus_if.bus_in = 32'h01020304;
    do_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus_if.bus_req && bus_if.bus_addr == 32'h20) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL drain_reach_20: request at 00000020 not seen, need it within 40 cycles");
    end
    bus_if.bus_ack = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h20 || pix_valid !== 1'b0) begin
        failures++;
        $display("FAIL drain_hold: req=%b addr=%h valid=%b, need 1 00000020 0",
                 bus_if.bus_req, bus_if.bus_addr, pix_valid);
      end
      @(negedge clk);
    end
    bus_if.bus_in = 32'hDEADBEEF;
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    checks++;
    if (bus_if.bus_req !== 1'b0 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_discard: req=%b valid=%b, need 0 0", bus_if.bus_req, pix_valid);
    end
    wait_req(5, found);
    checks++;
    if (!found || bus_if.bus_addr !== 32'h0) begin
      failures++;
      $display("FAIL drain_restart: found=%b addr=%h, need 1 00000000", found, bus_if.bus_addr);
    end
    bus_if.bus_in = 32'hCAFEF00D;
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'hCA) begin
      failures++;
      $display("FAIL drain_first_word: valid=%b data=%h, need 1 CA", pix_valid, pix_data);
    end
  endtask

  task automatic test_fs_ack();
    bit found = 1'b0;
    bus_if.bus_ack = 1'b1;
    bus_if.bus_in = 32'h0A0B0C0D;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus_if.bus_req && bus_if.bus_addr == 32'h8) found = 1'b1;
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++;
    if (!found || bus_if.bus_req !== 1'b0 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL fs_ack_idle: found=%b req=%b valid=%b, need 1 0 0",
               found, bus_if.bus_req, pix_valid);
    end
    @(negedge clk);
    checks++;
    if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h0) begin
      failures++;
      $display("FAIL fs_ack_restart: req=%b addr=%h, need 1 00000000",
               bus_if.bus_req, bus_if.bus_addr);
    end
  endtask

  task automatic test_underflow();
    bus_if.bus_ack = 1'b0;
    do_reset();
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || pix_data !== 8'h00 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_pre: valid=%b data=%h uf=%b, need 0 00 0",
               pix_valid, pix_data, underflow);
    end
    pix_rd = 1'b1;
    @(negedge clk);
    pix_rd = 1'b0;
    checks++;
    if (underflow !== 1'b1 || pix_data !== 8'h00) begin
      failures++;
      $display("FAIL underflow_set: uf=%b data=%h, need 1 00", underflow, pix_data);
    end
    @(negedge clk);
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sticky: uf=%b, need 1", underflow);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_clear: uf=%b, need 0", underflow);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_in = 32'h77777777;
    do_reset();
    wait_req(10, found);
    rst = 1'b1;
    #1;
    checks++;
    if (!found || bus_if.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_drop: found=%b req=%b, need 1 0", found, bus_if.bus_req);
    end
    bus_if.bus_ack = 1'b1;
    #4 rst = 1'b0;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    checks++;
    if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h0 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_ignore_ack: req=%b addr=%h valid=%b, need 1 00000000 0",
               bus_if.bus_req, bus_if.bus_addr, pix_valid);
    end
  endtask

  task automatic test_done();
    int n;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus2_if.bus_req) begin
          checks++;
          if (bus2_if.bus_addr !== 32'(n * 4)) begin
            failures++;
            $display("FAIL done_addr: pass %0d req %0d addr=%h, need %h",
                     pass, n, bus2_if.bus_addr, n * 4);
          end
          n++;
        end
      end
      checks++;
      if (n != 4 || bus2_if.bus_req !== 1'b0 || pix_valid2 !== 1'b1) begin
        failures++;
        $display("FAIL done_count: pass %0d requests=%0d req=%b valid=%b, need 4 0 1",
                 pass, n, bus2_if.bus_req, pix_valid2);
      end
      frame_start2 = 1'b1;
      @(negedge clk);
      frame_start2 = 1'b0;
    end
  endtask

  initial begin
    bus2_if.bus_ack = 1'b1;
    test_reset();
    test_fill();
    test_pixels();
    test_ack_delay();
    test_fs_drain();
    test_fs_ack();
    test_underflow();
    test_reset_mid();
    test_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 Parameter FB_BASE, default 32'h0000_0000: byte address of the first framebuffer word.
REQ-002 Parameter FB_WORDS, default 19200: 32-bit words per frame (320x240, 8 bpp).
REQ-003 Parameter FIFO_DEPTH, default 16: word FIFO depth, power of two, at least 4.
REQ-004 clk25MHz  input  1  pixel/bus clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 frame_start  input  1  one-cycle pulse at the start of vertical blank; restarts fetch at FB_BASE.
REQ-007 bus_req  output  1  read request to the memory bus.
REQ-008 bus_addr  output  32  byte address of the requested word, always 4-byte aligned.
REQ-009 bus_ack  input  1  memory acknowledge; bus_in is valid in any cycle where bus_ack=1.
REQ-010 bus_in  input  32  read data from memory.
REQ-011 pix_rd  input  1  pixel consumer pops one byte this cycle.
REQ-012 pix_data  output  8  current head pixel (RGB 3-3-2).
REQ-013 pix_valid  output  1  high when the FIFO holds at least one unread byte.
REQ-014 underflow  output  1  sticky flag: pix_rd was asserted while pix_valid=0.

Function
REQ-015 FSM states: IDLE, REQ, DRAIN, DONE.
REQ-016 IDLE -> REQ when (FIFO words + outstanding requests) < FIFO_DEPTH and the frame word count < FB_WORDS.
REQ-017 In REQ, bus_req=1 and bus_addr is held stable until a cycle in which bus_ack=1.
REQ-018 On that ack cycle: bus_in is written to the FIFO, bus_addr advances by 4, the word count increments, and the FSM goes to IDLE; bus_req=0 on the next cycle (one idle cycle minimum between requests).
REQ-019 When the word count reaches FB_WORDS, the FSM enters DONE: bus_req=0 and no further requests are issued until frame_start.
REQ-020 frame_start in IDLE or DONE: flush the FIFO, clear the byte pointer, set bus_addr=FB_BASE, clear the word count, clear underflow, go to IDLE.
REQ-021 frame_start in REQ: flush as in REQ-020, then go to DRAIN.
REQ-022 In DRAIN, bus_req and bus_addr stay unchanged until bus_ack; the acked word is discarded (not written to the FIFO); then go to IDLE with bus_addr=FB_BASE.
REQ-023 Byte order within a word is MSB first: bus_in[31:24] is the first pixel and bus_in[7:0] is the fourth.
REQ-024 pix_data is driven combinationally from the head word and the 2-bit byte pointer; pix_data=8'h00 whenever pix_valid=0.
REQ-025 pix_rd with pix_valid=1 advances the byte pointer; after byte 3, the head word is popped and the pointer wraps to 0.
REQ-026 A simultaneous FIFO write (ack) and pop into an empty FIFO is allowed; the written word becomes readable on the next cycle.
REQ-027 pix_rd with pix_valid=0: no state change except underflow<=1; underflow holds until reset or frame_start.
REQ-028 FIFO read and write pointers wrap modulo FIFO_DEPTH; the word count is ceil(log2(FIFO_DEPTH+1)) bits wide; the FIFO never overflows (guaranteed by REQ-016).
REQ-029 frame_start coincident with pix_rd: frame_start wins; the pop is ignored.
REQ-030 frame_start coincident with bus_ack in REQ: the ack completes the request, the word is discarded, and the FSM goes directly to IDLE.

Reset
REQ-031 Asserting reset at any time forces: state=IDLE, bus_req=0, bus_addr=FB_BASE, FIFO empty, byte pointer=0, word count=0, pix_valid=0, pix_data=8'h00, underflow=0.
REQ-032 After reset deasserts, the first bus_req rises on the first clock edge.
REQ-033 Reset asserted mid-request drops bus_req immediately (asynchronously); any later ack for that request is ignored.

Verification
REQ-034 Reset 30 ns, then bus_ack tied 1, bus_in=32'hAABBCCDD, pix_rd=0 -> exactly 16 requests at addresses 0x00, 0x04 ... 0x3C, then bus_req stays 0.
REQ-035 After REQ-034 fill, pix_rd held high for 4 cycles -> pix_data = AA, BB, CC, DD; one further request is then issued at 0x40.
REQ-036 bus_ack delayed 5 cycles -> bus_req and bus_addr stay stable throughout; the word is written once.
REQ-037 frame_start pulsed during REQ at address 0x20 -> DRAIN is entered, the acked word is discarded, pix_valid=0, and the next request goes to FB_BASE.
REQ-038 FB_WORDS=4, continuous ack -> 4 requests are issued, then DONE; after frame_start, requests resume at 0x00.
REQ-039 pix_rd on an empty FIFO -> underflow=1 and pix_data=00; underflow clears on frame_start.
